// File: rtl/sample_window_buffer_pkg.sv
// Shared constants for the sample window buffer and the difference engine.
// State codes, default widths and the window-plus-lag fill threshold.
package sample_window_buffer_pkg;

  localparam int SWB_DATA_WIDTH       = 16;
  localparam int SWB_WINDOW_SIZE_BITS = 8;
  localparam int SWB_MAX_TAU          = 40;

  typedef logic [1:0] swb_state_t;

  localparam swb_state_t ST_CLEAR = 2'd0;
  localparam swb_state_t ST_FILL  = 2'd1;
  localparam swb_state_t ST_READY = 2'd2;

  // Samples that must be stored before a window can be analysed.
  function automatic int need_samples(input int window_size_bits, input int max_tau);
    return (1 << window_size_bits) + max_tau;
  endfunction

endpackage

// File: rtl/sample_window_buffer_ram.sv
// Single-clock sample memory: one write port, one registered read port.
// Read-before-write: a read of the slot written in the same cycle returns old data.
module sample_ram
  import sample_window_buffer_pkg::*;
#(
  parameter int DATA_W = SWB_DATA_WIDTH,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is reset so the array stays block-RAM friendly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_window_buffer.sv
// Circular sample buffer feeding the windowed difference engine; releases HOP
// samples per completed window. Optional power-up memory sweep: SAMPLE_BUF_CLEAR_EN.
//
// state    | meaning
// CLEAR    | zeroing every memory entry after reset (SAMPLE_BUF_CLEAR_EN only)
// FILL     | collecting samples until window plus lag margin is stored
// READY    | window published at initial_address, waiting for window_done
module sample_window_buffer
  import sample_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = SWB_DATA_WIDTH,
  parameter int DEPTH_BITS       = 10,
  parameter int WINDOW_SIZE_BITS = SWB_WINDOW_SIZE_BITS,
  parameter int MAX_TAU          = SWB_MAX_TAU,
  parameter int HOP              = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [15:0]           address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [15:0]           initial_address,
  output logic                  window_ready,
  input  logic                  window_done,
  output logic                  overflow,
  output logic [DEPTH_BITS:0]   fill_count
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   NEED_CNT  = (DEPTH_BITS+1)'(need_samples(WINDOW_SIZE_BITS, MAX_TAU));
  localparam logic [DEPTH_BITS:0]   HOP_CNT   = (DEPTH_BITS+1)'(HOP);
  localparam logic [DEPTH_BITS-1:0] HOP_PTR   = DEPTH_BITS'(HOP);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);

  swb_state_t              r_state;
  swb_state_t              w_state_nxt;
  logic [DEPTH_BITS-1:0]   r_wr_ptr;
  logic [DEPTH_BITS-1:0]   r_base;
  logic [DEPTH_BITS:0]     r_fill;
  logic [DEPTH_BITS:0]     w_fill_nxt;
  logic                    r_overflow;
  logic                    w_full;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_clearing;
  logic                    w_clr_last;
  logic                    w_ram_we;
  logic [DEPTH_BITS-1:0]   w_ram_waddr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;

`ifdef SAMPLE_BUF_CLEAR_EN
  localparam swb_state_t ST_RESET = ST_CLEAR;
  logic [DEPTH_BITS-1:0] r_clr_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (w_clearing) begin
      r_clr_addr <= r_clr_addr + PTR_ONE;
    end
  end

  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_clr_last  = w_clearing && (r_clr_addr == '1);
  assign w_ram_we    = w_clearing || w_accept;
  assign w_ram_waddr = w_clearing ? r_clr_addr : r_wr_ptr;
  assign w_ram_wdata = w_clearing ? '0 : sample_in;
`else
  localparam swb_state_t ST_RESET = ST_FILL;

  assign w_clearing  = 1'b0;
  assign w_clr_last  = 1'b0;
  assign w_ram_we    = w_accept;
  assign w_ram_waddr = r_wr_ptr;
  assign w_ram_wdata = sample_in;
`endif

  // Counting from the window base, full means every slot is protected.
  assign w_full     = (r_fill == DEPTH_CNT);
  assign w_ready    = !w_full && !w_clearing;
  assign w_accept   = sample_valid && w_ready;
  assign w_done     = window_done && (r_state == ST_READY);
  assign w_fill_nxt = r_fill + (DEPTH_BITS+1)'(w_accept) - (w_done ? HOP_CNT : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_last)          w_state_nxt = ST_FILL;
      ST_FILL:  if (r_fill >= NEED_CNT)  w_state_nxt = ST_READY;
      ST_READY: if (window_done)         w_state_nxt = ST_FILL;
      default:                           w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_wr_ptr   <= '0;
      r_base     <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_done) begin
        r_base <= r_base + HOP_PTR;
      end
      if (sample_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sample_ram #(
    .DATA_W (DATA_WIDTH),
    .ADDR_W (DEPTH_BITS)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (DEPTH_BITS'(address)),
    .o_rdata (data_out)
  );

  assign sample_ready    = w_ready;
  assign initial_address = 16'(r_base);
  assign window_ready    = (r_state == ST_READY);
  assign overflow        = r_overflow;
  assign fill_count      = r_fill;

endmodule

// File: tb/tb_sample_window_buffer.sv
// Scoreboard bench for sample_window_buffer: stimulus queues expected values
// tagged with the cycle they are due; a negedge monitor compares and retires them.
module tb_sample_window_buffer;

`ifdef SAMPLE_BUF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  localparam int K_DATA  = 0;
  localparam int K_FILL  = 1;
  localparam int K_WRDY  = 2;
  localparam int K_INIT  = 3;
  localparam int K_SRDY  = 4;
  localparam int K_OVF   = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] address = '0;
  logic [15:0] data_out;
  logic [15:0] initial_address;
  logic        window_ready;
  logic        window_done = 1'b0;
  logic        overflow;
  logic [10:0] fill_count;

  always #5 clk = ~clk;

  sample_window_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .address         (address),
    .data_out        (data_out),
    .initial_address (initial_address),
    .window_ready    (window_ready),
    .window_done     (window_done),
    .overflow        (overflow),
    .fill_count      (fill_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    kind;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function int observe(input int kind);
    case (kind)
      K_DATA:  return int'(data_out);
      K_FILL:  return int'(fill_count);
      K_WRDY:  return int'(window_ready);
      K_INIT:  return int'(initial_address);
      K_SRDY:  return int'(sample_ready);
      K_OVF:   return int'(overflow);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        n_checks++;
        if (q[i].at < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed (due cycle %0d, now %0d)", q[i].nm, q[i].at, cyc);
        end else if (observe(q[i].kind) != q[i].val) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                   q[i].nm, observe(q[i].kind), q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int d, input int kind, input int val, input string nm);
    exp_t e;
    e.at = cyc + d;
    e.kind = kind;
    e.val = val;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic push(input int v);
    slot();
    sample_valid = 1'b1;
    sample_in    = 16'(v);
  endtask

  task automatic do_reset(input string tag);
    slot();
    reset        = 1'b1;
    sample_valid = 1'b0;
    window_done  = 1'b0;
    slot();
    reset = 1'b0;
    expect_v(0, K_FILL, 0, {tag, "_fill"});
    expect_v(0, K_WRDY, 0, {tag, "_wrdy"});
    expect_v(0, K_INIT, 0, {tag, "_init"});
    expect_v(0, K_OVF,  0, {tag, "_ovf"});
    expect_v(0, K_DATA, 0, {tag, "_data"});
    expect_v(0, K_SRDY, CLR ? 0 : 1, {tag, "_srdy"});
`ifdef SAMPLE_BUF_CLEAR_EN
    begin
      int n = 0;
      while (!sample_ready && n < 2000) begin
        n++;
        slot();
      end
      n_checks++;
      if (n != 1024) begin
        n_fail++;
        $display("FAIL %s_clear_len: sample_ready low for %0d cycles, expected 1024", tag, n);
      end
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks pending", q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) slot();

    // 1: fill to one below threshold, then the threshold sample
    do_reset("rst0");
    for (int v = 0; v < 296; v++) begin
      push(v);
      if (v == 294) begin
        expect_v(1, K_FILL, 295, "t1_fill295");
        expect_v(1, K_WRDY, 0,   "t1_wrdy_low");
      end
      if (v == 295) begin
        expect_v(1, K_FILL, 296, "t1_fill296");
        expect_v(1, K_WRDY, 0,   "t1_wrdy_lag");
        expect_v(2, K_WRDY, 1,   "t1_wrdy_high");
        expect_v(2, K_INIT, 0,   "t1_init0");
      end
    end
    slot();
    sample_valid = 1'b0;

    // 2: registered reads, modulo address wrap
    slot(); address = 16'd5;    expect_v(1, K_DATA, 5,   "t2_rd5");
    slot(); address = 16'd1029; expect_v(1, K_DATA, 5,   "t2_rd1029");
    slot(); address = 16'd295;  expect_v(1, K_DATA, 295, "t2_rd295");

    // 3: window_done releases one hop; done in FILL is ignored
    slot();
    window_done = 1'b1;
    expect_v(1, K_WRDY, 0,   "t3_wrdy_drop");
    expect_v(1, K_INIT, 256, "t3_init256");
    expect_v(1, K_FILL, 40,  "t3_fill40");
    slot(); window_done = 1'b0;
    slot(); window_done = 1'b1;
    expect_v(1, K_INIT, 256, "t3_ign_init");
    expect_v(1, K_FILL, 40,  "t3_ign_fill");
    slot(); window_done = 1'b0;
    for (int v = 296; v < 552; v++) begin
      push(v);
      if (v == 551) begin
        expect_v(1, K_FILL, 296, "t3_refill");
        expect_v(2, K_WRDY, 1,   "t3_wrdy_again");
        expect_v(2, K_INIT, 256, "t3_init_hold");
      end
    end
    slot();
    sample_valid = 1'b0;

    // 4: fill to capacity, overflow on the next sample
    do_reset("rst4");
    for (int v = 0; v < 1024; v++) begin
      push(v);
      if (v == 1022) expect_v(1, K_SRDY, 1, "t4_srdy_1023");
      if (v == 1023) begin
        expect_v(1, K_FILL, 1024, "t4_fill_full");
        expect_v(1, K_SRDY, 0,    "t4_srdy_full");
        expect_v(1, K_OVF,  0,    "t4_ovf_before");
        expect_v(1, K_WRDY, 1,    "t4_wrdy_full");
      end
    end
    slot();
    sample_in = 16'hBEEF;
    address   = 16'd0;
    expect_v(1, K_OVF,  1,    "t4_ovf_set");
    expect_v(1, K_FILL, 1024, "t4_fill_hold");
    expect_v(1, K_DATA, 0,    "t4_rd0_same");
    slot(); sample_valid = 1'b0; expect_v(1, K_DATA, 0, "t4_rd0_after");
    slot(); address = 16'd1023;  expect_v(1, K_DATA, 1023, "t4_rd1023");
    slot(); expect_v(0, K_OVF, 1, "t4_ovf_sticky");
    slot();
    window_done = 1'b1;
    expect_v(1, K_FILL, 768, "t4_fill768");
    expect_v(1, K_WRDY, 0,   "t4_wrdy_gap");
    expect_v(1, K_INIT, 256, "t4_init256");
    expect_v(1, K_SRDY, 1,   "t4_srdy_back");
    expect_v(2, K_WRDY, 1,   "t4_wrdy_return");
    expect_v(2, K_OVF,  1,   "t4_ovf_kept");
    slot(); window_done = 1'b0;

    // 5: read-before-write, then simultaneous write and window_done
    do_reset("rst5");
    for (int v = 0; v < 300; v++) begin
      push(16'h2000 + v);
      if (v == 7) begin
        address = 16'd7;
        expect_v(1, K_DATA, CLR ? 0 : 7, "t5_rd_old");
      end
      if (v == 8) expect_v(1, K_DATA, 16'h2007, "t5_rd_new");
      if (v == 299) begin
        expect_v(1, K_FILL, 300, "t5_fill300");
        expect_v(1, K_WRDY, 1,   "t5_wrdy");
      end
    end
    slot();
    sample_in   = 16'h2000 + 16'd300;
    window_done = 1'b1;
    expect_v(1, K_FILL, 45,  "t5_fill45");
    expect_v(1, K_INIT, 256, "t5_init256");
    expect_v(1, K_WRDY, 0,   "t5_wrdy_drop");
    slot();
    sample_valid = 1'b0;
    window_done  = 1'b0;
    address      = 16'd300;
    expect_v(1, K_WRDY, 0,                "t5_stay_fill");
    expect_v(1, K_FILL, 45,               "t5_fill_hold");
    expect_v(1, K_DATA, 16'h2000 + 300,   "t5_rd300");

    // 6: reach READY again, then reset mid-window
    for (int v = 301; v < 552; v++) begin
      push(v);
      if (v == 551) begin
        expect_v(1, K_FILL, 296, "t6_fill296");
        expect_v(2, K_WRDY, 1,   "t6_wrdy");
      end
    end
    slot();
    sample_valid = 1'b0;
    slot();
    do_reset("rst6");
`ifdef SAMPLE_BUF_CLEAR_EN
    slot(); address = 16'd5;   expect_v(1, K_DATA, 0, "t6_clr_rd5");
    slot(); address = 16'd551; expect_v(1, K_DATA, 0, "t6_clr_rd551");
`endif

    repeat (4) slot();
    while (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", q[0].nm, q[0].at);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
